// File: rtl/div_seq_unit.sv
// div_seq_unit -- iterative radix-2 restoring divider for the RV32M divide
// group (div, divu, rem, remu). Accepts one operation, iterates DATA_W cycles
// with stall held high, then returns the quotient or remainder with a
// one-cycle done pulse.
//
// Optional build macro: DIV_REUSE_EN
//   When defined, the operands, signedness, quotient and remainder of the last
//   normally completed operation are retained. A later start with identical
//   operands and signedness completes in one cycle from the stored value, so
//   a div followed by a rem of the same operands costs only one full pass.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   synchronous active-low reset
//   start   in   request, sampled only in IDLE
//   func3   in   3'h4 div, 3'h5 divu, 3'h6 rem, 3'h7 remu
//   op_a    in   dividend (rs1)
//   op_b    in   divisor (rs2)
//   flush   in   pipeline kill, aborts the current operation
//   busy    out  high in CALC and FIN
//   stall   out  holds the front end while an operation is accepted/running
//   done    out  one-cycle completion pulse
//   result  out  quotient or remainder, valid when done is high
module div_seq_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        func3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            state_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [DATA_W-1:0] result_reg;
  logic              is_rem_reg;
  logic              is_signed_reg;
  logic              sign_a_reg;
  logic              sign_b_reg;
  logic [DATA_W-1:0] b_abs_reg;
  logic [DATA_W-1:0] rem_reg;
  logic [DATA_W-1:0] quo_reg;
  logic [CNT_W-1:0]  cnt_reg;

  // Request decode. func3[2] marks the divide group, func3[0] clear means a
  // signed op, func3[1] set selects the remainder.
  logic              signed_in;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_abs;
  logic [DATA_W-1:0] b_abs;
  logic              accept;
  logic              b_zero;
  logic              ovf;

  assign signed_in = ~func3[0];
  assign a_neg     = signed_in & op_a[DATA_W-1];
  assign b_neg     = signed_in & op_b[DATA_W-1];
  assign a_abs     = a_neg ? -op_a : op_a;
  assign b_abs     = b_neg ? -op_b : op_b;
  assign accept    = (state_reg == S_IDLE) & start & func3[2] & ~flush;
  assign b_zero    = (op_b == '0);
  assign ovf       = signed_in & (op_a == INT_MIN) & (op_b == '1);

  // One restoring step. The shifted partial remainder is DATA_W+1 bits wide
  // so the trial subtract never loses the bit shifted in from the top.
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic              ge;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] quo_step;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;
  logic              last_iter;

  assign shifted   = {rem_reg, quo_reg[DATA_W-1]};
  assign ge        = (shifted >= {1'b0, b_abs_reg});
  assign diff      = shifted - {1'b0, b_abs_reg};
  // After a successful subtract the difference is below |b|, and after a
  // restore the shifted value is below |b|, so both fit in DATA_W bits.
  assign rem_step  = DATA_W'(ge ? diff : shifted);
  assign quo_step  = {quo_reg[DATA_W-2:0], ge};
  assign quo_fix   = (is_signed_reg & (sign_a_reg ^ sign_b_reg)) ? -quo_step : quo_step;
  assign rem_fix   = (is_signed_reg & sign_a_reg) ? -rem_step : rem_step;
  assign last_iter = (cnt_reg == CNT_W'(DATA_W - 1));

  // Stored-result shortcut.
  logic              reuse_hit;
  logic [DATA_W-1:0] reuse_quo;
  logic [DATA_W-1:0] reuse_rem;

`ifdef DIV_REUSE_EN
  logic [DATA_W-1:0] a_raw_reg;
  logic [DATA_W-1:0] b_raw_reg;
  logic [DATA_W-1:0] last_a_reg;
  logic [DATA_W-1:0] last_b_reg;
  logic [DATA_W-1:0] last_quo_reg;
  logic [DATA_W-1:0] last_rem_reg;
  logic              last_signed_reg;
  logic              reuse_valid_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_raw_reg       <= '0;
      b_raw_reg       <= '0;
      last_a_reg      <= '0;
      last_b_reg      <= '0;
      last_quo_reg    <= '0;
      last_rem_reg    <= '0;
      last_signed_reg <= 1'b0;
      reuse_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        a_raw_reg <= op_a;
        b_raw_reg <= op_b;
      end
      if (flush) begin
        reuse_valid_reg <= 1'b0;
      end else if ((state_reg == S_CALC) && last_iter) begin
        // Only full-length completions are recorded; special cases never are.
        reuse_valid_reg <= 1'b1;
        last_a_reg      <= a_raw_reg;
        last_b_reg      <= b_raw_reg;
        last_signed_reg <= is_signed_reg;
        last_quo_reg    <= quo_fix;
        last_rem_reg    <= rem_fix;
      end
    end
  end

  assign reuse_hit = reuse_valid_reg & (op_a == last_a_reg) & (op_b == last_b_reg) &
                     (signed_in == last_signed_reg);
  assign reuse_quo = last_quo_reg;
  assign reuse_rem = last_rem_reg;
`else
  assign reuse_hit = 1'b0;
  assign reuse_quo = '0;
  assign reuse_rem = '0;
`endif

  // Sequencer. result and done are registered on entry to FIN, so FIN is
  // exactly the cycle in which done is presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      result_reg    <= '0;
      is_rem_reg    <= 1'b0;
      is_signed_reg <= 1'b0;
      sign_a_reg    <= 1'b0;
      sign_b_reg    <= 1'b0;
      b_abs_reg     <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (accept) begin
            is_rem_reg    <= func3[1];
            is_signed_reg <= signed_in;
            sign_a_reg    <= a_neg;
            sign_b_reg    <= b_neg;
            b_abs_reg     <= b_abs;
            busy_reg      <= 1'b1;
            if (b_zero) begin
              result_reg <= func3[1] ? op_a : '1;
              done_reg   <= 1'b1;
              state_reg  <= S_FIN;
            end else if (ovf) begin
              result_reg <= func3[1] ? '0 : INT_MIN;
              done_reg   <= 1'b1;
              state_reg  <= S_FIN;
            end else if (reuse_hit) begin
              result_reg <= func3[1] ? reuse_rem : reuse_quo;
              done_reg   <= 1'b1;
              state_reg  <= S_FIN;
            end else begin
              rem_reg   <= '0;
              quo_reg   <= a_abs;
              cnt_reg   <= '0;
              state_reg <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            // Kill wins over a completion landing in the same cycle.
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            rem_reg <= rem_step;
            quo_reg <= quo_step;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (last_iter) begin
              result_reg <= is_rem_reg ? rem_fix : quo_fix;
              done_reg   <= 1'b1;
              state_reg  <= S_FIN;
            end
          end
        end
        S_FIN: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  // A flush arriving in the FIN cycle still has to suppress the pulse, and
  // done is already registered there, so it is masked on the way out.
  assign done   = done_reg & ~flush;
  assign busy   = busy_reg;
  assign result = result_reg;
  assign stall  = ((state_reg == S_IDLE) & start & func3[2] & ~flush) | (busy_reg & ~done);

endmodule

// File: tb/tb_div_seq_unit.sv
module tb_div_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  func3 = 3'h0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  div_seq_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .func3  (func3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef DIV_REUSE_EN
  localparam int REUSE_LAT = 1;
`else
  localparam int REUSE_LAT = 33;
`endif

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expectation and checks value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with result 0x%08h at cycle %0d, required none",
                 result, cyc);
      end else begin
        e = sb_q.pop_front();
        check({e.name, " result"}, result, e.res);
        check({e.name, " cycle"}, 32'(cyc), 32'(e.cyc));
        $display("txn %-18s result=0x%08h cycle=%0d", e.name, result, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start for a cycle; when push is set the expected result and
  // done cycle (issue cycle + lat) go to the scoreboard.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int lat, input string name,
                       input bit push, input logic exp_stall);
    func3 = f;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    if (push) sb_q.push_back('{res: exp_res, cyc: cyc + lat, name: name});
    #1;
    check({name, " stall"}, {31'd0, stall}, {31'd0, exp_stall});
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 80; i++) begin
      if (sb_q.size() == 0) break;
      tick();
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d results outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  int c0;

  initial begin
    // Reset state
    repeat (3) tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset result", result, 32'd0);
    rst_n = 1'b1;
    tick();

    // Unsigned pair, remainder may come from the stored result
    issue(3'h5, 32'd100, 32'd7, 32'd14, 33, "divu 100/7", 1'b1, 1'b1);
    repeat (5) tick();
    check("calc stall", {31'd0, stall}, 32'd1);
    check("calc busy", {31'd0, busy}, 32'd1);
    drain();
    issue(3'h7, 32'd100, 32'd7, 32'd2, REUSE_LAT, "remu 100/7", 1'b1, 1'b1);
    drain();

    // Signed truncation toward zero
    issue(3'h6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem -7/2", 1'b1, 1'b1);
    drain();
    issue(3'h4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, REUSE_LAT, "div -7/2", 1'b1, 1'b1);
    drain();
    issue(3'h4, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, 33, "div -8/-3", 1'b1, 1'b1);
    drain();
    issue(3'h6, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, REUSE_LAT, "rem -8/-3", 1'b1, 1'b1);
    drain();
    issue(3'h7, 32'hFFFF_FFFF, 32'h10, 32'hF, 33, "remu ffffffff/16", 1'b1, 1'b1);
    drain();

    // Divide by zero and signed overflow complete in one cycle
    issue(3'h4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div 5/0", 1'b1, 1'b1);
    drain();
    issue(3'h7, 32'd5, 32'd0, 32'd5, 1, "remu 5/0", 1'b1, 1'b1);
    drain();
    issue(3'h4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div min/-1", 1'b1, 1'b1);
    drain();
    issue(3'h6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem min/-1", 1'b1, 1'b1);
    drain();

    // func3 outside the divide group is ignored
    issue(3'h1, 32'd10, 32'd0, 32'd0, 0, "func3 1", 1'b0, 1'b0);
    tick();
    check("bad func3 busy", {31'd0, busy}, 32'd0);

    // Flush at cycle 10, restart at cycle 11
    c0 = cyc;
    issue(3'h5, 32'd1000, 32'd3, 32'd0, 0, "divu 1000/3 flush", 1'b0, 1'b1);
    while (cyc < c0 + 10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush cycle", 32'(cyc), 32'(c0 + 11));
    issue(3'h5, 32'd9, 32'd3, 32'd3, 33, "divu 9/3", 1'b1, 1'b1);
    drain();

    // Reset in the middle of an operation
    c0 = cyc;
    issue(3'h5, 32'd1000, 32'd3, 32'd0, 0, "divu 1000/3 reset", 1'b0, 1'b1);
    while (cyc < c0 + 5) tick();
    rst_n = 1'b0;
    tick();
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    check("midreset result", result, 32'd0);
    rst_n = 1'b1;
    repeat (40) tick();

    // Start while busy is dropped; original result survives and holds
    issue(3'h5, 32'd100, 32'd7, 32'd14, 33, "divu 100/7 again", 1'b1, 1'b1);
    repeat (2) tick();
    issue(3'h4, 32'd50, 32'd0, 32'd0, 0, "div 50/0 busy", 1'b0, 1'b1);
    drain();
    repeat (3) tick();
    check("hold result", result, 32'd14);
    check("hold done", {31'd0, done}, 32'd0);

    repeat (5) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d left, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
